regfile_bypass: RTL and testbench
=================================

// Module: regfile_bypass
// PURPOSE
//  Parametrised register file for the ID stage. Provides two registered read ports and one general write port.
//  Adds a dedicated R0 accumulator read/write port, write-to-read bypass, and a pending-write scoreboard.
//  The scoreboard lets ID stall on load-use hazards.
//  Sits between decode and the ID/EX pipeline register; replaces the fixed 16x16 register file.
// PARAMETERS
//  DATA_W  16  register width in bits
//  DEPTH   16  number of registers (2..256)
//  ADDR_W  4   address width; must equal $clog2(DEPTH)
//  BYPASS  1   1 = a same-cycle write is forwarded to the read outputs; 0 = reads return the old contents
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous, active-low reset
//  RA1       in   ADDR_W  read address, port 1
//  RA2       in   ADDR_W  read address, port 2
//  RD1       out  DATA_W  registered read data, port 1
//  RD2       out  DATA_W  registered read data, port 2
//  R0R       out  DATA_W  registered copy of register 0
//  RegWrite  in   1       general write enable
//  WA1       in   ADDR_W  general write address
//  WD1       in   DATA_W  general write data
//  R0W       in   1       register-0 write enable
//  R0D       in   DATA_W  register-0 write data
//  PendSet   in   1       mark a register as awaiting a write (issued load)
//  PendAddr  in   ADDR_W  register to mark pending
//  Busy1     out  1       registered: RA1 target was pending; valid in the same cycle as RD1
//  Busy2     out  1       registered: RA2 target was pending; valid in the same cycle as RD2
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - registers 1..5 load 0x0F00, 0x0050, 0xFF0F, 0xF0FF, 0x0040; all other registers load 0
//   - RD1, RD2, R0R, Busy1, Busy2 and every pending bit clear to 0
//   - reset overrides any in-flight write or PendSet; nothing is held over after deassertion
//  Read latency is 1 cycle:
//   - RD1, RD2, R0R are sampled at the clock edge, from the state before that edge's writes
//   - RA1/RA2 >= DEPTH read 0 and Busy=0
//  Write timing:
//   - RegWrite writes WD1 to mem[WA1] at the edge
//   - R0W writes R0D to mem[0] at the edge
//   - WA1 >= DEPTH is ignored
//   - RegWrite with WA1=0 and R0W in the same cycle: R0W wins and mem[0]=R0D
//  Bypass (BYPASS=1):
//   - if RA1/RA2 equals the address written this cycle, RD1/RD2 take the written data
//   - R0R takes R0D when R0W=1, else WD1 when RegWrite=1 and WA1=0
//   - the same priority as the write itself applies
//   - with BYPASS=0, reads always return the pre-edge contents
//  Scoreboard (one pending bit per register):
//   - PendSet sets pend[PendAddr]
//   - a write to address A clears pend[A]; R0W clears pend[0]
//   - set and clear of the same address in one cycle: set wins (new producer)
//   - Busy1/2 <= the pend bit of RA1/RA2 after this cycle's set/clear when BYPASS=1; before it when BYPASS=0
//   - Busy1/2 is forced 0 for address >= DEPTH
//  There is no handshake back-pressure; the block accepts every command every cycle.
//  DATA_W arithmetic: none. Data is stored and forwarded unmodified; no sign or zero extension.
// STRUCTURE
//  Shared package id_pkg:
//   - REG_W and REG_DEPTH defaults
//   - localparam array RF_RESET_VAL[0:15] holding the reset values above
//   - for DEPTH > 16, the array is zero-extended
//  Sub-module rf_scoreboard (pend vector, set/clear priority, Busy lookup) is instantiated once.
//  Storage, bypass muxes and read registers stay in regfile_bypass.
//  Storage is a flop array; no SRAM macro; the async reset clears it.
// TESTING
//  1. Reset, then read RA1=1, RA2=5 for one cycle -> RD1=0x0F00, RD2=0x0040, R0R=0, Busy1=Busy2=0.
//  2. RegWrite WA1=3, WD1=0xABCD with RA1=3, BYPASS=1 -> RD1=0xABCD next cycle.
//     Repeat with BYPASS=0 -> RD1=0xFF0F, then 0xABCD one cycle later.
//  3. RegWrite WA1=0, WD1=0x1111 and R0W, R0D=0x2222 in the same cycle -> R0R=0x2222; mem[0] reads 0x2222 afterwards.
//  4. PendSet PendAddr=7, then RA1=7 -> Busy1=1.
//     RegWrite WA1=7 alone -> Busy1=0 (BYPASS=1).
//     PendSet=7 together with RegWrite WA1=7 -> Busy1 stays 1.
//  5. Assert rst mid-burst: writes to 2 and 9 plus PendSet 9 in flight -> all outputs 0 immediately.
//     After release, mem[2]=0x0050, mem[9]=0, Busy=0.
//  6. DEPTH=12, ADDR_W=4: write WA1=13 -> no register changes; RA1=13 -> RD1=0, Busy1=0.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// Shared ID-stage register-file constants: default geometry and architectural reset values.
package id_pkg;

    localparam int unsigned REG_W     = 16;
    localparam int unsigned REG_DEPTH = 16;

    localparam logic [15:0] RF_RESET_VAL [0:15] = '{
        16'h0000, 16'h0F00, 16'h0050, 16'hFF0F,
        16'hF0FF, 16'h0040, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

    // Registers beyond the architectural 16 come out of reset as zero.
    function automatic logic [15:0] rf_reset_val(input int unsigned idx);
        if (idx < 16) return RF_RESET_VAL[idx[3:0]];
        return '0;
    endfunction

endpackage

// File: rtl/regfile_bypass_if.sv
// Decode-side bus of the ID-stage register file: read, write, R0 and scoreboard signals.
interface regfile_bypass_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] RA1;
    logic [ADDR_W-1:0] RA2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [DATA_W-1:0] R0R;
    logic              RegWrite;
    logic [ADDR_W-1:0] WA1;
    logic [DATA_W-1:0] WD1;
    logic              R0W;
    logic [DATA_W-1:0] R0D;
    logic              PendSet;
    logic [ADDR_W-1:0] PendAddr;
    logic              Busy1;
    logic              Busy2;

    modport master (
        output RA1, RA2, RegWrite, WA1, WD1, R0W, R0D, PendSet, PendAddr,
        input  RD1, RD2, R0R, Busy1, Busy2
    );

    modport slave (
        input  RA1, RA2, RegWrite, WA1, WD1, R0W, R0D, PendSet, PendAddr,
        output RD1, RD2, R0R, Busy1, Busy2
    );
endinterface

// File: rtl/regfile_bypass_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issued loads, cleared by writeback.
module rf_scoreboard import id_pkg::*; #(
    parameter int unsigned DEPTH  = REG_DEPTH,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              busy1,
    output logic              busy2
);
    localparam int unsigned SPAN = 1 << ADDR_W;

    logic [SPAN-1:0] valid;
    logic [SPAN-1:0] pend;
    logic [SPAN-1:0] pend_nxt;
    logic [SPAN-1:0] set_vec;
    logic [SPAN-1:0] clr_vec;
    logic [SPAN-1:0] lookup;

    for (genvar g = 0; g < int'(SPAN); g++) begin : g_valid
        assign valid[g] = (g < int'(DEPTH));
    end

    // A new producer issued in the same cycle as the old one retires must stay pending.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (pend_set) set_vec[pend_addr] = valid[pend_addr];
        if (wr_en)    clr_vec[wr_addr]   = 1'b1;
        if (r0_wr)    clr_vec[0]         = 1'b1;
        pend_nxt = set_vec | (pend & ~clr_vec);
        lookup   = (BYPASS != 0) ? pend_nxt : pend;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend  <= '0;
            busy1 <= 1'b0;
            busy2 <= 1'b0;
        end else begin
            pend  <= pend_nxt;
            busy1 <= lookup[ra1] & valid[ra1];
            busy2 <= lookup[ra2] & valid[ra2];
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// ID-stage register file: two registered read ports, general + R0 write ports,
// optional write-to-read forwarding and a load-use scoreboard.
module regfile_bypass import id_pkg::*; #(
    parameter int unsigned DATA_W = REG_W,
    parameter int unsigned DEPTH  = REG_DEPTH,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    regfile_bypass_if.slave  bus
);
    localparam int unsigned SPAN = 1 << ADDR_W;

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] mem_rd [SPAN];
    logic [SPAN-1:0]   addr_valid;

    logic              wen0;
    logic [DATA_W-1:0] wdata0;
    logic              gen_we;
    logic [DATA_W-1:0] rd1_nxt;
    logic [DATA_W-1:0] rd2_nxt;
    logic [DATA_W-1:0] r0r_nxt;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] r0r_q;

    for (genvar g = 0; g < int'(SPAN); g++) begin : g_valid
        assign addr_valid[g] = (g < int'(DEPTH));
    end

    // R0W outranks a general write aimed at register 0.
    assign wen0   = bus.R0W | (bus.RegWrite & (bus.WA1 == '0));
    assign wdata0 = bus.R0W ? bus.R0D : bus.WD1;
    assign gen_we = bus.RegWrite & addr_valid[bus.WA1];

    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] v;
        v = mem_rd[ra];
        if (BYPASS != 0 && addr_valid[ra]) begin
            if (wen0 && ra == '0)
                v = wdata0;
            else if (gen_we && bus.WA1 == ra)
                v = bus.WD1;
        end
        return v;
    endfunction

    // Out-of-range addresses read through zero-filled padding entries.
    always_comb begin
        for (int unsigned i = 0; i < SPAN; i++) mem_rd[i] = '0;
        for (int unsigned i = 0; i < DEPTH; i++) mem_rd[i] = mem[i];
        rd1_nxt = fwd(bus.RA1);
        rd2_nxt = fwd(bus.RA2);
        r0r_nxt = (BYPASS != 0 && wen0) ? wdata0 : mem[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(rf_reset_val(i));
            rd1_q <= '0;
            rd2_q <= '0;
            r0r_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i == 0 && wen0)
                    mem[i] <= wdata0;
                else if (gen_we && bus.WA1 == ADDR_W'(i))
                    mem[i] <= bus.WD1;
            end
            rd1_q <= rd1_nxt;
            rd2_q <= rd2_nxt;
            r0r_q <= r0r_nxt;
        end
    end

    assign bus.RD1 = rd1_q;
    assign bus.RD2 = rd2_q;
    assign bus.R0R = r0r_q;

    rf_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .pend_set  (bus.PendSet),
        .pend_addr (bus.PendAddr),
        .wr_en     (gen_we),
        .wr_addr   (bus.WA1),
        .r0_wr     (bus.R0W),
        .ra1       (bus.RA1),
        .ra2       (bus.RA2),
        .busy1     (bus.Busy1),
        .busy2     (bus.Busy2)
    );

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench: forwarding, no-forwarding and reduced-depth register files side by side.
module tb_regfile_bypass;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regfile_bypass_if #(.DATA_W(16), .ADDR_W(4)) ifb ();
    regfile_bypass_if #(.DATA_W(16), .ADDR_W(4)) ifn ();
    regfile_bypass_if #(.DATA_W(16), .ADDR_W(4)) ifd ();

    regfile_bypass #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .BYPASS(1)) u_byp (
        .clk (clk), .rst (rst), .bus (ifb)
    );
    regfile_bypass #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .BYPASS(0)) u_nobyp (
        .clk (clk), .rst (rst), .bus (ifn)
    );
    regfile_bypass #(.DATA_W(16), .DEPTH(12), .ADDR_W(4), .BYPASS(1)) u_d12 (
        .clk (clk), .rst (rst), .bus (ifd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic r0w, input logic [15:0] r0d,
                       input logic ps, input logic [3:0] pa);
        ifb.RA1 = ra1; ifb.RA2 = ra2; ifb.RegWrite = we; ifb.WA1 = wa; ifb.WD1 = wd;
        ifb.R0W = r0w; ifb.R0D = r0d; ifb.PendSet = ps; ifb.PendAddr = pa;
        ifn.RA1 = ra1; ifn.RA2 = ra2; ifn.RegWrite = we; ifn.WA1 = wa; ifn.WD1 = wd;
        ifn.R0W = r0w; ifn.R0D = r0d; ifn.PendSet = ps; ifn.PendAddr = pa;
    endtask

    task automatic drvd(input logic [3:0] ra1, input logic [3:0] ra2,
                        input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic ps, input logic [3:0] pa);
        ifd.RA1 = ra1; ifd.RA2 = ra2; ifd.RegWrite = we; ifd.WA1 = wa; ifd.WD1 = wd;
        ifd.R0W = 1'b0; ifd.R0D = '0; ifd.PendSet = ps; ifd.PendAddr = pa;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drv(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        drvd(0, 0, 0, 0, 16'h0, 0, 0);
        tick;
        tick;
        check("rst_rd1",   ifb.RD1,   16'h0);
        check("rst_rd2",   ifb.RD2,   16'h0);
        check("rst_r0r",   ifb.R0R,   16'h0);
        check("rst_busy1", ifb.Busy1, 1'b0);
        check("rst_busy2", ifb.Busy2, 1'b0);
        rst = 1'b1;

        // reset contents
        drv(1, 5, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        tick;
        check("t1_rd1",   ifb.RD1,   16'h0F00);
        check("t1_rd2",   ifb.RD2,   16'h0040);
        check("t1_r0r",   ifb.R0R,   16'h0000);
        check("t1_busy1", ifb.Busy1, 1'b0);
        check("t1_busy2", ifb.Busy2, 1'b0);
        check("t1_n_rd1", ifn.RD1,   16'h0F00);

        // forwarding of a general write
        drv(3, 0, 1, 3, 16'hABCD, 0, 16'h0, 0, 0);
        tick;
        check("t2_b_rd1", ifb.RD1, 16'hABCD);
        check("t2_n_rd1", ifn.RD1, 16'hFF0F);
        drv(3, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        tick;
        check("t2_n_rd1_late", ifn.RD1, 16'hABCD);
        check("t2_b_rd1_late", ifb.RD1, 16'hABCD);

        // R0W beats RegWrite to register 0
        drv(0, 0, 1, 0, 16'h1111, 1, 16'h2222, 0, 0);
        tick;
        check("t3_b_r0r", ifb.R0R, 16'h2222);
        check("t3_b_rd1", ifb.RD1, 16'h2222);
        check("t3_n_r0r", ifn.R0R, 16'h0000);
        drv(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        tick;
        check("t3_b_mem0", ifb.RD1, 16'h2222);
        check("t3_n_mem0", ifn.RD1, 16'h2222);
        check("t3_n_r0r",  ifn.R0R, 16'h2222);

        // scoreboard set / clear / set-wins
        drv(7, 0, 0, 0, 16'h0, 0, 16'h0, 1, 7);
        tick;
        check("t4_b_set",  ifb.Busy1, 1'b1);
        check("t4_n_set",  ifn.Busy1, 1'b0);
        drv(7, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        tick;
        check("t4_b_hold", ifb.Busy1, 1'b1);
        check("t4_n_hold", ifn.Busy1, 1'b1);
        drv(7, 0, 1, 7, 16'h7777, 0, 16'h0, 0, 0);
        tick;
        check("t4_b_clr",  ifb.Busy1, 1'b0);
        check("t4_n_clr",  ifn.Busy1, 1'b1);
        check("t4_b_rd1",  ifb.RD1,   16'h7777);
        drv(7, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        tick;
        check("t4_n_clr_late", ifn.Busy1, 1'b0);
        drv(7, 0, 1, 7, 16'h7070, 0, 16'h0, 1, 7);
        tick;
        check("t4_b_setwin", ifb.Busy1, 1'b1);
        check("t4_b_rd1b",   ifb.RD1,   16'h7070);
        drv(7, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        tick;
        check("t4_b_setwin2", ifb.Busy1, 1'b1);
        check("t4_n_setwin2", ifn.Busy1, 1'b1);
        drv(0, 0, 0, 0, 16'h0, 0, 16'h0, 1, 0);
        tick;
        check("t4_b_r0pend", ifb.Busy2, 1'b1);
        check("t4_n_r0pend", ifn.Busy2, 1'b0);
        drv(0, 0, 0, 0, 16'h0, 1, 16'h0005, 0, 0);
        tick;
        check("t4_b_r0clr", ifb.Busy2, 1'b0);
        check("t4_n_r0clr", ifn.Busy2, 1'b1);
        check("t4_b_r0r",   ifb.R0R,   16'h0005);

        // asynchronous reset in the middle of a burst
        drv(2, 9, 1, 2, 16'h1234, 0, 16'h0, 1, 9);
        tick;
        check("t5_b_rd1",   ifb.RD1,   16'h1234);
        check("t5_b_busy2", ifb.Busy2, 1'b1);
        drv(2, 9, 1, 9, 16'h9999, 0, 16'h0, 1, 9);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_rd1",   ifb.RD1,   16'h0);
        check("t5_async_rd2",   ifb.RD2,   16'h0);
        check("t5_async_r0r",   ifb.R0R,   16'h0);
        check("t5_async_busy1", ifb.Busy1, 1'b0);
        check("t5_async_busy2", ifb.Busy2, 1'b0);
        check("t5_async_n_rd1", ifn.RD1,   16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drv(2, 9, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        tick;
        check("t5_mem2",  ifb.RD1,   16'h0050);
        check("t5_mem9",  ifb.RD2,   16'h0000);
        check("t5_busy2", ifb.Busy2, 1'b0);
        check("t5_n_mem2", ifn.RD1,  16'h0050);
        drv(0, 7, 0, 0, 16'h0, 0, 16'h0, 0, 0);
        tick;
        check("t5_mem0",   ifb.RD1,   16'h0000);
        check("t5_pend7",  ifb.Busy2, 1'b0);

        // reduced depth: out-of-range writes, reads and pending marks are inert
        drvd(13, 0, 1, 13, 16'hFFFF, 1, 13);
        tick;
        check("t6_rd1_oor",   ifd.RD1,   16'h0);
        check("t6_busy1_oor", ifd.Busy1, 1'b0);
        drvd(1, 13, 0, 0, 16'h0, 0, 0);
        tick;
        check("t6_mem1",      ifd.RD1,   16'h0F00);
        check("t6_rd2_oor",   ifd.RD2,   16'h0);
        check("t6_busy2_oor", ifd.Busy2, 1'b0);
        drvd(11, 5, 1, 11, 16'hBEEF, 1, 11);
        tick;
        check("t6_rd1_top",   ifd.RD1,   16'hBEEF);
        check("t6_busy1_top", ifd.Busy1, 1'b1);
        check("t6_mem5",      ifd.RD2,   16'h0040);
        drvd(12, 11, 0, 0, 16'h0, 0, 0);
        tick;
        check("t6_rd1_12",    ifd.RD1,   16'h0);
        check("t6_busy1_12",  ifd.Busy1, 1'b0);
        check("t6_mem11",     ifd.RD2,   16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
